magnitude_comparator_bist: RTL

- Hardware stimulus driver and self-checker for the 4-bit magnitude comparator; it is the driving and checking end of the comparator's A/B → X/Y/Z interface.
- Generates operand pairs from an LFSR, holds them for a settle window, then samples X/Y/Z and checks them against an internal golden compare.
- Counts vectors and mismatches; reports pass/fail. Sits beside the comparator in a synthesizable self-test wrapper.

---
 rtl/magnitude_comparator_bist_if.sv | 14 +
 rtl/magnitude_comparator_bist.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/magnitude_comparator_bist_if.sv
// Comparator operand/result bus: the BIST drives A/B (master), the comparator answers X/Y/Z (slave).
// Purely combinational response path; no flow control on this bus.
interface magnitude_comparator_bist_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_x;
    logic             cmp_y;
    logic             cmp_z;

    modport master (output cmp_a, output cmp_b, input cmp_x, input cmp_y, input cmp_z);
    modport slave  (input cmp_a, input cmp_b, output cmp_x, output cmp_y, output cmp_z);
endinterface

// File: rtl/magnitude_comparator_bist.sv
// Self-test driver/checker for a WIDTH-bit magnitude comparator; CMP_BIST_EXHAUSTIVE_EN swaps the LFSR for an exhaustive up-counter.
// Latency: first vector one cycle after start is sampled, SETTLE_CYCLES+1 cycles per vector, done after RUN_LEN*(SETTLE_CYCLES+1)+1.
// Backpressure: none; start is honoured only in IDLE/DONE and ignored while a run is busy.
module magnitude_comparator_bist #(
    parameter int         WIDTH         = 4,
    parameter int         NUM_VECTORS   = 16,
    parameter logic [7:0] SEED          = 8'hA5,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    magnitude_comparator_bist_if.master  cmp,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [15:0]                  vec_count,
    output logic [15:0]                  err_count
);

    localparam int LW  = 2 * WIDTH;
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

`ifdef CMP_BIST_EXHAUSTIVE_EN
    localparam logic [LW-1:0] SEED_EFF = '0;
    localparam logic [16:0]   RUN_LEN  = 17'(1 << LW);
`else
    localparam logic [LW-1:0] SEED_EFF = (SEED == 8'h00) ? LW'(1) : LW'(SEED);
    localparam logic [16:0]   RUN_LEN  = 17'(NUM_VECTORS);
`endif

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             start_q;
    logic             restart;
    logic [LW-1:0]    lfsr;
    logic [LW-1:0]    lfsr_nxt;
    logic [SCW-1:0]   settle_cnt;
    logic             settle_end;
    logic             last_vec;
    logic             mismatch;
    logic [2:0]       exp_xyz;
    logic [16:0]      vec_inc;
    logic [15:0]      vec_nxt;
    logic [15:0]      err_nxt;

`ifdef CMP_BIST_EXHAUSTIVE_EN
    assign lfsr_nxt = lfsr + LW'(1);
`else
    // Fibonacci taps generalise x^8+x^6+x^5+x^4+1 to any 2*WIDTH >= 5
    assign lfsr_nxt = {lfsr[LW-2:0], lfsr[LW-1] ^ lfsr[LW-3] ^ lfsr[LW-4] ^ lfsr[LW-5]};
`endif

    assign exp_xyz    = {cmp.cmp_a > cmp.cmp_b, cmp.cmp_a == cmp.cmp_b, cmp.cmp_a < cmp.cmp_b};
    assign mismatch   = {cmp.cmp_x, cmp.cmp_y, cmp.cmp_z} != exp_xyz;
    assign vec_inc    = {1'b0, vec_count} + 17'd1;
    assign last_vec   = (vec_inc == RUN_LEN);
    assign settle_end = (settle_cnt == SCW'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        case (state)
            IDLE: begin
                if (start_q) begin
                    restart   = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_end) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = last_vec ? DONE : SETTLE;
            end
            DONE: begin
                if (start_q) begin
                    restart   = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vec_nxt = vec_count;
        err_nxt = err_count;
        if (restart) begin
            vec_nxt = '0;
            err_nxt = '0;
        end else if (state == CHECK) begin
            vec_nxt = vec_inc[15:0];
            if (mismatch && (err_count != 16'hFFFF)) begin
                err_nxt = err_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= 1'b0;
            lfsr       <= SEED_EFF;
            cmp.cmp_a  <= '0;
            cmp.cmp_b  <= '0;
            settle_cnt <= '0;
            vec_count  <= '0;
            err_count  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            // start is registered so a request seen mid-run can never leak into DONE
            start_q   <= start && ((state == IDLE) || (state == DONE));
            vec_count <= vec_nxt;
            err_count <= err_nxt;
            busy      <= (state_nxt == SETTLE) || (state_nxt == CHECK);
            done      <= (state_nxt == DONE);
            pass      <= (state_nxt == DONE) && (err_nxt == 16'd0);
            if (restart) begin
                lfsr       <= SEED_EFF;
                cmp.cmp_a  <= SEED_EFF[LW-1:WIDTH];
                cmp.cmp_b  <= SEED_EFF[WIDTH-1:0];
                settle_cnt <= '0;
            end else if (state == SETTLE) begin
                settle_cnt <= settle_cnt + SCW'(1);
            end else if (state == CHECK) begin
                lfsr       <= lfsr_nxt;
                settle_cnt <= '0;
                if (!last_vec) begin
                    cmp.cmp_a <= lfsr_nxt[LW-1:WIDTH];
                    cmp.cmp_b <= lfsr_nxt[WIDTH-1:0];
                end
            end
        end
    end

endmodule
